gly_axil_regs: RTL

AXI4-Lite slave register block: the responder that a bus master (or the master VIP in the block-design bench) writes and reads through the S00_AXI port of the gly peripheral. It holds four read/write scratch registers, two free-running transaction counters and a constant ID word. It returns OKAY/SLVERR responses with at most one outstanding transaction per direction.

---
 rtl/gly_axil_regs.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/gly_axil_regs.sv
// AXI4-Lite slave with four RW scratch registers, write/read transaction counters and a constant ID word.
// Build option: define GLY_AXIL_WSTRB_EN to honour WSTRB per byte; otherwise any nonzero strobe writes the whole word.
module gly_axil_regs #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [31:0] C_ID_VALUE         = 32'h676C7935
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_e;

   w_state_e         w_state_q, w_state_d;
   r_state_e         r_state_q, r_state_d;
   logic [1:0]       bresp_q, bresp_d;
   logic [1:0]       rresp_q, rresp_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [DW-1:0]    regs_q [4];
   logic [DW-1:0]    regs_d [4];
   logic [31:0]      wr_cnt_q, wr_cnt_d;
   logic [31:0]      rd_cnt_q, rd_cnt_d;
   logic [DW-1:0]    wmerge;
   logic [2:0]       w_slot;
   logic [2:0]       r_slot;
   logic             unused_inputs;

   assign w_slot = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign r_slot = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // New contents of the addressed RW register after applying the write strobes
   always_comb begin
      wmerge = regs_q[w_slot[1:0]];
`ifdef GLY_AXIL_WSTRB_EN
      for (int b = 0; b < DW/8; b++) begin
         if (S_AXI_WSTRB[b]) begin
            wmerge[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
         end
      end
`else
      if (|S_AXI_WSTRB) begin
         wmerge = S_AXI_WDATA;
      end
`endif
   end

   // READY is raised one cycle after both AW and W are seen; the handshake edge commits the write
   always_comb begin
      w_state_d = w_state_q;
      bresp_d   = bresp_q;
      wr_cnt_d  = wr_cnt_q;
      regs_d    = regs_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               w_state_d = W_ACCEPT;
            end
         end
         W_ACCEPT: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               w_state_d = W_RESP;
               wr_cnt_d  = wr_cnt_q + 32'd1;
               if (w_slot[2]) begin
                  bresp_d = RESP_SLVERR;
               end else begin
                  bresp_d                = RESP_OKAY;
                  regs_d[w_slot[1:0]]    = wmerge;
               end
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read data is captured from current state, so a same-cycle write to that slot is not yet visible
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_cnt_d  = rd_cnt_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (S_AXI_ARVALID) begin
               r_state_d = R_ACCEPT;
            end
         end
         R_ACCEPT: begin
            if (S_AXI_ARVALID) begin
               r_state_d = R_DATA;
               rd_cnt_d  = rd_cnt_q + 32'd1;
               rresp_d   = RESP_OKAY;
               unique case (r_slot)
                  3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[r_slot[1:0]];
                  3'd4:    rdata_d = wr_cnt_q;
                  3'd5:    rdata_d = rd_cnt_q;
                  3'd6:    rdata_d = C_ID_VALUE;
                  default: begin
                     rdata_d = '0;
                     rresp_d = RESP_SLVERR;
                  end
               endcase
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         bresp_q   <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         regs_q    <= regs_d;
      end
   end

   assign S_AXI_AWREADY = (w_state_q == W_ACCEPT);
   assign S_AXI_WREADY  = (w_state_q == W_ACCEPT);
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = (r_state_q == R_ACCEPT);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

endmodule
